// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Handshaked load/store unit standing in for a single-cycle MEM stage when the
//   data memory is slow or shared. Each access is issued as a valid/ready
//   request; loads then wait for a response (bounded by MAX_WAIT cycles). The
//   pipeline is held via mem_stall until the access finishes. Store data is
//   forwarded from WB and replicated across byte lanes. Load data is aligned and
//   sign/zero-extended.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     ex_mem_*                  access request from the EX/MEM register
//     wb_*                      WB write port, used to forward store data
//     dmem_req_* / dmem_addr /  request channel to data memory
//       dmem_we/be/wdata
//     dmem_rsp_*                load response channel
//     mem_stall                 holds IF..EX/MEM while an access is in flight
//     mem_load_valid/data       one-cycle load result
//     mem_bus_err               one-cycle pulse on response timeout
//     mem_misalign              one-cycle pulse on a trapped misaligned access
//
//   Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
//   accesses instead of issuing them. Without it mem_misalign is tied low.
//
//   state | meaning
//   IDLE  | waiting for a load/store in EX/MEM; capture request fields
//   REQ   | dmem_req_valid high, request fields held until ready
//   RESP  | load issued, counting cycles until response or timeout
//   DONE  | access finished; stall released, result/error pulses asserted

module mem_stage_lsu #(
   parameter int XLEN     = 32,
   parameter int ALEN     = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_mem_mem_read,
   input  logic            ex_mem_mem_write,
   input  logic [XLEN-1:0] ex_mem_alu_result,
   input  logic [XLEN-1:0] ex_mem_write_data,
   input  logic [2:0]      ex_mem_funct3,
   input  logic [4:0]      ex_mem_rs2,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_write_data,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [ALEN-1:0] dmem_addr,
   output logic            dmem_we,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rsp_rdata,
   output logic            mem_stall,
   output logic            mem_load_valid,
   output logic [XLEN-1:0] mem_load_data,
   output logic            mem_bus_err,
   output logic            mem_misalign
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

   state_t          state_q;
   logic            req_valid_q;
   logic            we_q;
   logic [ALEN-1:0] addr_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;
   logic [2:0]      funct3_q;
   logic [1:0]      lane_q;
   logic [CW-1:0]   cnt_q;
   logic            load_valid_q;
   logic            bus_err_q;
   logic [XLEN-1:0] load_data_q;

   logic            access;
   logic [1:0]      lane_d;
   logic            sz_byte;
   logic            sz_half;
   logic [XLEN-1:0] src_data;
   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d;

   assign access = ex_mem_mem_read | ex_mem_mem_write;
   assign lane_d = ex_mem_alu_result[1:0];

   // LBU/LHU encodings only mean byte/half for loads; as stores they fall to word.
   assign sz_byte = (ex_mem_funct3 == 3'b000) || (!ex_mem_mem_write && ex_mem_funct3 == 3'b100);
   assign sz_half = (ex_mem_funct3 == 3'b001) || (!ex_mem_mem_write && ex_mem_funct3 == 3'b101);

   assign src_data = (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_mem_rs2) ? wb_write_data
                                                                            : ex_mem_write_data;

   // Enables are truncated to 4 bits, so a half at lane 3 only enables byte 3.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = src_data;
      if (sz_byte) begin
         be_d    = 4'(4'b0001 << lane_d);
         wdata_d = {4{src_data[7:0]}};
      end else if (sz_half) begin
         be_d    = 4'(4'b0011 << lane_d);
         wdata_d = {2{src_data[15:0]}};
      end
   end

   function automatic logic [XLEN-1:0] extract(input logic [2:0]      f3,
                                               input logic [1:0]      lane,
                                               input logic [XLEN-1:0] word);
      logic [XLEN-1:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
         3'b001:  extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
         3'b100:  extract = {{(XLEN-8){1'b0}}, sh[7:0]};
         3'b101:  extract = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: extract = word;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_q;
   logic misaligned;
   assign misaligned   = (sz_half && lane_d[0]) || (!sz_byte && !sz_half && lane_d != 2'b00);
   assign mem_misalign = misalign_q;
`else
   assign mem_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_valid_q  <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         lane_q       <= '0;
         cnt_q        <= '0;
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
         load_data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (access) begin
                  we_q     <= ex_mem_mem_write;
                  addr_q   <= {ex_mem_alu_result[ALEN-1:2], 2'b00};
                  be_q     <= be_d;
                  wdata_q  <= wdata_d;
                  funct3_q <= ex_mem_funct3;
                  lane_q   <= lane_d;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     misalign_q   <= 1'b1;
                     load_valid_q <= !ex_mem_mem_write;
                     load_data_q  <= '0;
                     state_q      <= S_DONE;
                  end else begin
                     req_valid_q <= 1'b1;
                     state_q     <= S_REQ;
                  end
`else
                  req_valid_q <= 1'b1;
                  state_q     <= S_REQ;
`endif
               end
            end
            S_REQ: begin
               // A response arriving in the accept cycle is ignored on purpose.
               if (dmem_req_ready) begin
                  req_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= we_q ? S_DONE : S_RESP;
               end
            end
            S_RESP: begin
               if (dmem_rsp_valid) begin
                  load_data_q  <= extract(funct3_q, lane_q, dmem_rsp_rdata);
                  load_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end else if (cnt_q == CW'(MAX_WAIT)) begin
                  load_data_q  <= '0;
                  load_valid_q <= 1'b1;
                  bus_err_q    <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_stall      = (state_q == S_IDLE && access) || state_q == S_REQ || state_q == S_RESP;
   assign dmem_req_valid = req_valid_q;
   assign dmem_addr      = addr_q;
   assign dmem_we        = we_q;
   assign dmem_be        = be_q;
   assign dmem_wdata     = wdata_q;
   assign mem_load_valid = load_valid_q;
   assign mem_load_data  = load_data_q;
   assign mem_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

   localparam int MAXW = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mem_mem_read, ex_mem_mem_write;
   logic [31:0] ex_mem_alu_result, ex_mem_write_data;
   logic [2:0]  ex_mem_funct3;
   logic [4:0]  ex_mem_rs2;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_write_data;
   logic        dmem_req_valid, dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        mem_stall, mem_load_valid, mem_bus_err, mem_misalign;
   logic [31:0] mem_load_data;

   always #5 clk = ~clk;

   mem_stage_lsu #(.XLEN(32), .ALEN(32), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst),
      .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
      .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_write_data(ex_mem_write_data),
      .ex_mem_funct3(ex_mem_funct3), .ex_mem_rs2(ex_mem_rs2),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .mem_stall(mem_stall), .mem_load_valid(mem_load_valid), .mem_load_data(mem_load_data),
      .mem_bus_err(mem_bus_err), .mem_misalign(mem_misalign)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic        is_load;
      logic        issue;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] data;
      logic        err;
      logic        mis;
      int          stall;
   } exp_t;

   exp_t sb[$];

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
      logic [63:0] ext;
      logic [7:0]  b;
      logic [15:0] h;
      int          sh;
      ext = {32'h0, w};
      sh  = 8 * int'(a);
      b   = ext[sh +: 8];
      h   = ext[sh +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // rsp_wait < 0 means memory never answers; rsp_in_req drives a bogus response
   // in the cycle the request is accepted.
   task automatic run_op(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                         input logic [4:0] rs2, input logic wbwe, input logic [4:0] wbrd,
                         input logic [31:0] wbdata, input int rdy_wait, input int rsp_wait,
                         input logic rsp_in_req, input logic [31:0] rsp_word);
      exp_t        e, got;
      logic [1:0]  a;
      logic [31:0] src;
      logic        szb, szh, req_seen, in_resp, done, accept, rsp_now;
      int          rdy_cnt, resp_cnt, stalls;

      a   = addr[1:0];
      src = (wbwe && wbrd != 5'd0 && wbrd == rs2) ? wbdata : wd;
      szb = (f3 == 3'b000) || (!wr && f3 == 3'b100);
      szh = (f3 == 3'b001) || (!wr && f3 == 3'b101);
      e.is_load = !wr;
      e.addr    = {addr[31:2], 2'b00};
      if (szb) begin
         e.be = (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 : (a == 2'd2) ? 4'b0100 : 4'b1000;
         e.wdata = {src[7:0], src[7:0], src[7:0], src[7:0]};
      end else if (szh) begin
         e.be = (a == 2'd0) ? 4'b0011 : (a == 2'd1) ? 4'b0110 : (a == 2'd2) ? 4'b1100 : 4'b1000;
         e.wdata = {src[15:0], src[15:0]};
      end else begin
         e.be    = 4'b1111;
         e.wdata = src;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      e.mis = (szh && a[0]) || (!szb && !szh && a != 2'd0);
`else
      e.mis = 1'b0;
`endif
      e.issue = !e.mis;
      e.err   = e.is_load && !e.mis && rsp_wait < 0;
      e.data  = (!e.is_load || e.mis || rsp_wait < 0) ? 32'h0 : model_load(f3, a, rsp_word);
      if (e.mis) e.stall = 1;
      else e.stall = 2 + rdy_wait + (e.is_load ? ((rsp_wait >= 0) ? rsp_wait + 1 : MAXW + 1) : 0);
      sb.push_back(e);

      ex_mem_mem_read   = rd;
      ex_mem_mem_write  = wr;
      ex_mem_alu_result = addr;
      ex_mem_write_data = wd;
      ex_mem_funct3     = f3;
      ex_mem_rs2        = rs2;
      wb_reg_write      = wbwe;
      wb_rd             = wbrd;
      wb_write_data     = wbdata;
      req_seen = 1'b0; in_resp = 1'b0; done = 1'b0;
      rdy_cnt = 0; resp_cnt = 0; stalls = 0;

      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         #1;
         dmem_req_ready = dmem_req_valid && (rdy_cnt >= rdy_wait);
         dmem_rsp_valid = (in_resp && rsp_wait >= 0 && resp_cnt == rsp_wait) ||
                          (rsp_in_req && dmem_req_ready);
         dmem_rsp_rdata = in_resp ? rsp_word : 32'hA5A5_5A5A;
         if (mem_stall) stalls++;
         if (dmem_req_valid) begin
            req_seen = 1'b1;
            chk({name, ".req_addr"}, dmem_addr, e.addr);
            chk({name, ".req_we"}, {31'h0, dmem_we}, {31'h0, wr});
            chk({name, ".req_be"}, {28'h0, dmem_be}, {28'h0, e.be});
            if (wr) chk({name, ".req_wdata"}, dmem_wdata, e.wdata);
         end
         if (!mem_stall) begin
            got = sb.pop_front();
            chk({name, ".load_valid"}, {31'h0, mem_load_valid}, {31'h0, got.is_load});
            if (got.is_load) chk({name, ".load_data"}, mem_load_data, got.data);
            chk({name, ".bus_err"}, {31'h0, mem_bus_err}, {31'h0, got.err});
            chk({name, ".misalign"}, {31'h0, mem_misalign}, {31'h0, got.mis});
            chk({name, ".stall_cycles"}, stalls, got.stall);
            chk({name, ".issued"}, {31'h0, req_seen}, {31'h0, got.issue});
            ex_mem_mem_read  = 1'b0;
            ex_mem_mem_write = 1'b0;
            dmem_req_ready   = 1'b0;
            dmem_rsp_valid   = 1'b0;
            done = 1'b1;
         end else begin
            accept  = dmem_req_valid && dmem_req_ready;
            rsp_now = in_resp && dmem_rsp_valid;
            if (dmem_req_valid && !dmem_req_ready) rdy_cnt++;
            @(posedge clk);
            if (in_resp) begin
               if (rsp_now) in_resp = 1'b0;
               else resp_cnt++;
            end
            if (accept && !wr) begin
               in_resp  = 1'b1;
               resp_cnt = 0;
            end
            @(negedge clk);
            wb_reg_write = 1'b0;
         end
      end
      if (!done) begin
         chk({name, ".timeout"}, 32'h1, 32'h0);
         void'(sb.pop_front());
      end
      @(negedge clk);
      chk({name, ".lv_pulse"}, {31'h0, mem_load_valid}, 32'h0);
      chk({name, ".err_pulse"}, {31'h0, mem_bus_err}, 32'h0);
      chk({name, ".mis_pulse"}, {31'h0, mem_misalign}, 32'h0);
      chk({name, ".idle_stall"}, {31'h0, mem_stall}, 32'h0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".stall"}, {31'h0, mem_stall}, 32'h0);
      chk({name, ".req_valid"}, {31'h0, dmem_req_valid}, 32'h0);
      chk({name, ".addr"}, dmem_addr, 32'h0);
      chk({name, ".we_be"}, {27'h0, dmem_we, dmem_be}, 32'h0);
      chk({name, ".wdata"}, dmem_wdata, 32'h0);
      chk({name, ".load_valid"}, {31'h0, mem_load_valid}, 32'h0);
      chk({name, ".load_data"}, mem_load_data, 32'h0);
      chk({name, ".err_mis"}, {30'h0, mem_bus_err, mem_misalign}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
      ex_mem_alu_result = '0; ex_mem_write_data = '0; ex_mem_funct3 = '0; ex_mem_rs2 = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_write_data = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      //      name      rd wr addr          wdata         f3      rs2 wbwe wbrd wbdata        rdy rsp req-rsp word
      run_op("lw",     1, 0, 32'h100, 32'h0,         3'b010, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'hDEADBEEF);
      run_op("lb",     1, 0, 32'h103, 32'h0,         3'b000, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'h80FFFFFF);
      run_op("lbu",    1, 0, 32'h103, 32'h0,         3'b100, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'h80FFFFFF);
      run_op("lhu",    1, 0, 32'h102, 32'h0,         3'b101, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'h80FFFFFF);
      run_op("lh",     1, 0, 32'h102, 32'h0,         3'b001, 5'd0, 0, 5'd0, 32'h0,         1,  2, 0, 32'h80FFFFFF);
      run_op("sb_fwd", 0, 1, 32'h201, 32'h0BAD0BAD,  3'b000, 5'd5, 1, 5'd5, 32'h12345678,  0,  0, 0, 32'h0);
      run_op("sw_hold",0, 1, 32'h300, 32'hCAFEF00D,  3'b010, 5'd7, 0, 5'd0, 32'h0,         4,  0, 0, 32'h0);
      run_op("sh_x0",  0, 1, 32'h202, 32'hAAAABEEF,  3'b001, 5'd0, 1, 5'd0, 32'h11112222,  0,  0, 0, 32'h0);
      run_op("sw_nofw",0, 1, 32'h304, 32'h01020304,  3'b010, 5'd6, 1, 5'd9, 32'hFFFFFFFF,  1,  0, 0, 32'h0);
      run_op("sw_inv", 0, 1, 32'h308, 32'h55667788,  3'b101, 5'd3, 1, 5'd3, 32'h99AABBCC,  0,  0, 0, 32'h0);
      run_op("lw_rreq",1, 0, 32'h10C, 32'h0,         3'b010, 5'd0, 0, 5'd0, 32'h0,         0,  2, 1, 32'h13579BDF);
      run_op("lw_inv", 1, 0, 32'h110, 32'h0,         3'b111, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'h87654321);
      run_op("lw_tmo", 1, 0, 32'h114, 32'h0,         3'b010, 5'd0, 0, 5'd0, 32'h0,         0, -1, 0, 32'h0);
      run_op("lh_a1",  1, 0, 32'h101, 32'h0,         3'b001, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'h8899AABB);
      run_op("sh_a3",  0, 1, 32'h203, 32'h0000ABCD,  3'b001, 5'd0, 0, 5'd0, 32'h0,         0,  0, 0, 32'h0);

      for (int i = 0; i < 6; i++) begin
         logic        w;
         logic [2:0]  f;
         logic [31:0] ad;
         w  = 1'($urandom_range(0, 1));
         f  = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
         ad = 32'h400 + 32'($urandom_range(0, 15));
         run_op("rand", !w, w, ad, $urandom, f, 5'd4, 1'($urandom_range(0, 1)), 5'd4, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 3), 0, $urandom);
      end

      // reset while a load waits in RESP; a later response must be ignored
      dmem_req_ready    = 1'b1;
      ex_mem_mem_read   = 1'b1;
      ex_mem_alu_result = 32'h120;
      ex_mem_funct3     = 3'b010;
      @(negedge clk);
      @(negedge clk);
      chk("rst_resp.in_resp", {30'h0, mem_stall, dmem_req_valid}, 32'h2);
      rst             = 1'b1;
      ex_mem_mem_read = 1'b0;
      dmem_req_ready  = 1'b0;
      @(negedge clk);
      rst            = 1'b0;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'hFEEDFACE;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      chk_all_zero("rst_resp");
      @(negedge clk);
      chk_all_zero("rst_after");
      chk("sb_empty", sb.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
